dvfs_sequencer: RTL and testbench
=================================

// Module: dvfs_sequencer
// PURPOSE
//  - Consumer end of the DPMU V/F control interface. Accepts target voltage/frequency codes for core1, core2, mem
//    and drives the regulator/clock-gen control lines in a safe order: voltages up, then frequencies, then voltages down.
//  - Voltage moves one code step at a time with a settle wait after each step, so a frequency is never applied above
//    what the current voltage supports.
// PARAMETERS
//  - V_SETTLE  default 4  cycles waited after each voltage step (>=1)
//  - F_SETTLE  default 2  cycles waited after the frequency apply (>=1)
//  - CNT_W     default 4  settle counter width; must hold max(V_SETTLE,F_SETTLE)
// PORTS
//  - clk           in   1  clock; all flops posedge
//  - rst           in   1  reset, synchronous, active-high
//  - req_valid     in   1  target request valid
//  - req_ready     out  1  high only in IDLE; request accepted on posedge with req_valid & req_ready
//  - tgt_v         in   6  {vcore1,vcore2,vmem}, 2b each
//  - tgt_f         in   9  {fcore1,fcore2,fmem}, 3b each
//  - thermal_trip  in   1  emergency input (used only with DVFS_EMERG_EN)
//  - v_out         out  6  applied voltage codes, same packing as tgt_v
//  - f_out         out  9  applied frequency codes, same packing as tgt_f
//  - busy          out  1  high in every state except IDLE
//  - done          out  1  one-cycle pulse when a request completes
//  - tripped       out  1  sticky emergency flag (0 without DVFS_EMERG_EN)
// BEHAVIOUR
//  - Reset: v_out=6'b010101, f_out=9'b010010010 (DPMU NORMAL levels), state IDLE, req_ready=1, busy=0, done=0,
//    tripped=0, counter=0. Reset mid-sequence abandons it; the captured target is discarded.
//  - Accept edge k: tgt_v/tgt_f are registered, state leaves IDLE. Inputs are ignored until the next accept.
//  - States: IDLE -> V_UP -> F_SET -> V_DN -> DONE -> IDLE. A phase with no work is skipped and costs 0 cycles.
//  - V_UP: each step raises by +1 every domain whose applied v < target. Others hold. Each step = 1 update cycle
//    + V_SETTLE wait cycles. Repeats until no domain is below target.
//  - F_SET: entered only if any f differs. All three f written together in 1 cycle, then F_SETTLE wait cycles.
//  - V_DN: same as V_UP, with -1 for every domain whose applied v > target.
//  - Mixed requests (some domains up, some down) follow the same order; each domain moves only in its own phase.
//  - DONE: done=1 and req_ready=1 for exactly one cycle. A request held on req_valid is accepted on that edge.
//  - Latency from accept edge k to done high: k + up*(1+V_SETTLE) + fchg*(1+F_SETTLE) + dn*(1+V_SETTLE) + 1.
//    up/dn = max step count over domains; fchg is 0 or 1. A no-op request gives done at k+1.
//  - Codes are unsigned, 2b/3b, with no wrap. Steps never overshoot the target.
//  - req_valid while busy: req_ready=0, nothing is captured, the request is held off.
// CONFIGURATION
//  - DVFS_EMERG_EN defined: thermal_trip=1 sampled on any posedge with rst=0 causes, at that edge:
//      f_out=0 (safe at any voltage), v_out holds, tripped=1, state=IDLE, no done pulse, counter cleared.
//      tripped stays set until the next accepted request or reset. Trip in IDLE also forces f_out=0.
//      Trip has priority over acceptance in the same cycle.
//  - DVFS_EMERG_EN undefined: thermal_trip is ignored, tripped is tied to 0, no trip logic is built.
// TESTING
//  - Reset hold 2 cycles, then release -> v_out=010101, f_out=010010010, req_ready=1, busy=0, done=0.
//  - Default params, from reset, request v=111111 f=111111111 at edge k -> v_out=101010 at k+1, 111111 at k+6,
//    f_out=all-1 at k+11, done pulse at k+14.
//  - From v=111111 f=all-1, request v=000000 f=000000000 -> f_out=0 at k+1, v_out 101010@k+4, 010101@k+9,
//    000000@k+14, done@k+19; f is never nonzero after v starts dropping.
//  - Request identical to applied codes -> done at k+1; v_out and f_out unchanged. A second request held on
//    req_valid during busy is accepted on the done edge.
//  - DVFS_EMERG_EN: thermal_trip during V_UP settle -> next edge f_out=0, tripped=1, busy=0, no done.
//    The next accept clears tripped. Without the macro the same stimulus completes normally.
//  - rst=1 during F_SET settle -> next edge reset values restored and busy=0.

Source files
------------

// File: rtl/dvfs_sequencer_if.sv
// dvfs_sequencer_if: V/F control bus between the DPMU (master) and the dvfs_sequencer (slave).
// Request side: req_valid/req_ready handshake with tgt_v {vcore1,vcore2,vmem} and tgt_f {fcore1,fcore2,fmem}.
// thermal_trip is the emergency input. Status side: applied v_out/f_out codes, busy, done pulse, sticky tripped.
interface dvfs_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] tgt_v;
  logic [8:0] tgt_f;
  logic       thermal_trip;
  logic [5:0] v_out;
  logic [8:0] f_out;
  logic       busy;
  logic       done;
  logic       tripped;
  modport master (output req_valid, tgt_v, tgt_f, thermal_trip,
                  input  req_ready, v_out, f_out, busy, done, tripped);
  modport slave  (input  req_valid, tgt_v, tgt_f, thermal_trip,
                  output req_ready, v_out, f_out, busy, done, tripped);
endinterface

// File: rtl/dvfs_sequencer.sv
// dvfs_sequencer: applies DPMU V/F targets in safe order (voltages up, frequencies, voltages down).
// Ports: clk, rst (sync, active-high), bus (dvfs_sequencer_if.slave) carrying the request handshake,
// targets, thermal_trip, applied v_out/f_out, busy, done and tripped.
// Optional emergency trip logic is built only when DVFS_EMERG_EN is defined.
module dvfs_sequencer #(
  parameter int V_SETTLE = 4,
  parameter int F_SETTLE = 2,
  parameter int CNT_W    = 4
) (
  input logic clk,
  input logic rst,
  dvfs_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, V_UP, F_SET, V_DN, DONE} state_t;
  localparam logic [5:0] V_NORM = 6'b010101;
  localparam logic [8:0] F_NORM = 9'b010010010;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0] v_q, v_d, tv_q, tv_d, v_inc, v_dec;
  logic [8:0] f_q, f_d, tf_q, tf_d;
  logic done_q, done_d;
  // Look ahead to the first phase that still has work, so empty phases cost no cycles.
  // DONE is a closing cycle; the done pulse is registered out of it into the following IDLE cycle.
  function automatic state_t pick(input logic [5:0] v, tv, input logic [8:0] f, tf);
    logic up, dn;
    up = 1'b0;
    dn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up |= v[2*i+:2] < tv[2*i+:2];
      dn |= v[2*i+:2] > tv[2*i+:2];
    end
    return up ? V_UP : (f != tf) ? F_SET : dn ? V_DN : DONE;
  endfunction
  always_comb begin
    v_inc = v_q;
    v_dec = v_q;
    for (int i = 0; i < 3; i++) begin
      v_inc[2*i+:2] = v_q[2*i+:2] < tv_q[2*i+:2] ? v_q[2*i+:2] + 2'd1 : v_q[2*i+:2];
      v_dec[2*i+:2] = v_q[2*i+:2] > tv_q[2*i+:2] ? v_q[2*i+:2] - 2'd1 : v_q[2*i+:2];
    end
  end
`ifdef DVFS_EMERG_EN
  logic tripped_q, tripped_d;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      v_q     <= V_NORM;
      f_q     <= F_NORM;
      tv_q    <= V_NORM;
      tf_q    <= F_NORM;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      f_q     <= f_d;
      tv_q    <= tv_d;
      tf_q    <= tf_d;
      done_q  <= done_d;
    end
  end
`ifdef DVFS_EMERG_EN
  always_ff @(posedge clk) tripped_q <= rst ? 1'b0 : tripped_d;
`endif
  // cnt_q == 0 inside a phase marks its update cycle; nonzero counts down the settle wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    f_d     = f_q;
    tv_d    = tv_q;
    tf_d    = tf_q;
    done_d  = 1'b0;
`ifdef DVFS_EMERG_EN
    tripped_d = tripped_q;
`endif
    if (state_q == IDLE) begin
      if (bus.req_valid) begin
        tv_d    = bus.tgt_v;
        tf_d    = bus.tgt_f;
        state_d = pick(v_q, bus.tgt_v, f_q, bus.tgt_f);
`ifdef DVFS_EMERG_EN
        tripped_d = 1'b0;
`endif
      end
    end else if (state_q == DONE) begin
      done_d  = 1'b1;
      state_d = IDLE;
    end else if (cnt_q == '0) begin
      v_d   = state_q == V_UP ? v_inc : state_q == V_DN ? v_dec : v_q;
      f_d   = state_q == F_SET ? tf_q : f_q;
      cnt_d = state_q == F_SET ? CNT_W'(F_SETTLE) : CNT_W'(V_SETTLE);
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) state_d = pick(v_q, tv_q, f_q, tf_q);
    end
`ifdef DVFS_EMERG_EN
    if (bus.thermal_trip) begin
      f_d       = '0;
      state_d   = IDLE;
      cnt_d     = '0;
      done_d    = 1'b0;
      tripped_d = 1'b1;
    end
`endif
  end
  always_comb begin
    bus.req_ready = state_q == IDLE;
    bus.busy      = state_q != IDLE;
    bus.v_out     = v_q;
    bus.f_out     = f_q;
    bus.done      = done_q;
  end
`ifdef DVFS_EMERG_EN
  assign bus.tripped = tripped_q;
`else
  logic unused_trip;
  assign unused_trip = bus.thermal_trip;
  assign bus.tripped = 1'b0;
`endif
endmodule

// File: tb/tb_dvfs_sequencer.sv
// tb_dvfs_sequencer: directed self-checking bench for dvfs_sequencer with default parameters.
module tb_dvfs_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  dvfs_sequencer_if bus();
  dvfs_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic [5:0] v, input logic [8:0] f);
    bus.req_valid = 1'b1;
    bus.tgt_v = v;
    bus.tgt_f = f;
    tick(1);
    bus.req_valid = 1'b0;
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.tgt_v = '0;
    bus.tgt_f = '0;
    bus.thermal_trip = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("rst_v", bus.v_out, 6'h15);
    chk("rst_f", bus.f_out, 9'h092);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tripped", bus.tripped, 0);
    // full raise: two voltage steps then frequency
    req(6'h3f, 9'h1ff);
    chk("up_busy", bus.busy, 1);
    chk("up_ready", bus.req_ready, 0);
    tick(1);
    chk("up_v_k1", bus.v_out, 6'h2a);
    tick(5);
    chk("up_v_k6", bus.v_out, 6'h3f);
    tick(4);
    chk("up_f_k10", bus.f_out, 9'h092);
    tick(1);
    chk("up_f_k11", bus.f_out, 9'h1ff);
    tick(2);
    chk("up_done_k13", bus.done, 0);
    tick(1);
    chk("up_done_k14", bus.done, 1);
    chk("up_ready_k14", bus.req_ready, 1);
    tick(1);
    chk("up_done_k15", bus.done, 0);
    // full drop: frequency first, then three voltage steps
    req(6'h00, 9'h000);
    tick(1);
    chk("dn_f_k1", bus.f_out, 9'h000);
    chk("dn_v_k1", bus.v_out, 6'h3f);
    tick(3);
    chk("dn_v_k4", bus.v_out, 6'h2a);
    chk("dn_f_k4", bus.f_out, 9'h000);
    tick(5);
    chk("dn_v_k9", bus.v_out, 6'h15);
    tick(5);
    chk("dn_v_k14", bus.v_out, 6'h00);
    tick(4);
    chk("dn_done_k18", bus.done, 0);
    tick(1);
    chk("dn_done_k19", bus.done, 1);
    tick(1);
    // no-op request
    req(6'h00, 9'h000);
    tick(1);
    chk("nop_done", bus.done, 1);
    chk("nop_v", bus.v_out, 6'h00);
    chk("nop_f", bus.f_out, 9'h000);
    tick(1);
    chk("nop_done_off", bus.done, 0);
    // request A, then B held on req_valid while busy
    bus.req_valid = 1'b1;
    bus.tgt_v = 6'h01;
    bus.tgt_f = 9'h000;
    tick(1);
    bus.tgt_v = 6'h00;
    bus.tgt_f = 9'h001;
    tick(1);
    chk("hold_v_k1", bus.v_out, 6'h01);
    chk("hold_ready_k1", bus.req_ready, 0);
    tick(4);
    chk("hold_done_k5", bus.done, 0);
    tick(1);
    chk("hold_done_k6", bus.done, 1);
    chk("hold_ready_k6", bus.req_ready, 1);
    chk("hold_f_k6", bus.f_out, 9'h000);
    tick(1);
    bus.req_valid = 1'b0;
    chk("hold_busy_k7", bus.busy, 1);
    tick(1);
    chk("hold_f_k8", bus.f_out, 9'h001);
    chk("hold_v_k8", bus.v_out, 6'h01);
    tick(3);
    chk("hold_v_k11", bus.v_out, 6'h00);
    tick(4);
    chk("hold_done_k15", bus.done, 0);
    tick(1);
    chk("hold_done_k16", bus.done, 1);
    tick(1);
    // thermal trip during voltage-up settle
    req(6'h15, 9'h092);
    tick(1);
    chk("trip_v_k1", bus.v_out, 6'h15);
    tick(1);
    bus.thermal_trip = 1'b1;
    tick(1);
    bus.thermal_trip = 1'b0;
`ifdef DVFS_EMERG_EN
    chk("trip_f", bus.f_out, 9'h000);
    chk("trip_flag", bus.tripped, 1);
    chk("trip_busy", bus.busy, 0);
    chk("trip_v", bus.v_out, 6'h15);
    tick(3);
    chk("trip_nodone", bus.done, 0);
    chk("trip_sticky", bus.tripped, 1);
    req(6'h15, 9'h092);
    chk("trip_clear", bus.tripped, 0);
    chk("trip_re_busy", bus.busy, 1);
    tick(1);
    chk("trip_re_f", bus.f_out, 9'h092);
    tick(3);
    chk("trip_re_done", bus.done, 1);
`else
    chk("notrip_busy", bus.busy, 1);
    chk("notrip_flag", bus.tripped, 0);
    chk("notrip_f_k3", bus.f_out, 9'h001);
    tick(3);
    chk("notrip_f_k6", bus.f_out, 9'h092);
    tick(3);
    chk("notrip_done_k9", bus.done, 1);
    chk("notrip_v", bus.v_out, 6'h15);
`endif
    tick(1);
    // reset during frequency settle
    req(6'h15, 9'h1ff);
    tick(1);
    chk("rstmid_f_k1", bus.f_out, 9'h1ff);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rstmid_f", bus.f_out, 9'h092);
    chk("rstmid_v", bus.v_out, 6'h15);
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_ready", bus.req_ready, 1);
    chk("rstmid_done", bus.done, 0);
    req(6'h15, 9'h092);
    tick(1);
    chk("rstmid_nop_done", bus.done, 1);
    tick(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
